// File: rtl/ov_pkg.sv
// Shared definitions for the DVP capture front end: format codes,
// capture FSM states and VSYNC polarity constants.
package ov_pkg;

  localparam logic [1:0] FMT_RGB565 = 2'd0;
  localparam logic [1:0] FMT_RGB444 = 2'd1;
  localparam logic [1:0] FMT_GRAY8  = 2'd2;

  localparam logic VSYNC_POL_LOW  = 1'b0;
  localparam logic VSYNC_POL_HIGH = 1'b1;

  typedef enum logic [2:0] {
    SYNC_WAIT = 3'd0,
    SKIP      = 3'd1,
    ARMED     = 3'd2,
    ACTIVE    = 3'd3,
    IGNORE    = 3'd4
  } ov_state_e;

endpackage

// File: rtl/ov_pix_fmt.sv
// Combinational pixel converter: RGB565 in, selected format out in a
// zero-padded 16-bit word. The parent registers the result.
module ov_pix_fmt
  import ov_pkg::*;
(
  input  logic [15:0] pix,
  input  logic [1:0]  fmt,
  output logic [15:0] data
);

  logic [4:0] r;
  logic [5:0] g;
  logic [4:0] b;
  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;
  logic [9:0] sum;
  logic [7:0] gray;

  assign r = pix[15:11];
  assign g = pix[10:5];
  assign b = pix[4:0];

  // Replicate MSBs so full-scale channels expand to exactly 0xFF.
  assign r8   = {r, r[4:2]};
  assign g8   = {g, g[5:4]};
  assign b8   = {b, b[4:2]};
  assign sum  = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
  assign gray = 8'(sum >> 2);

  always_comb begin
    data = pix;
    case (fmt)
      FMT_RGB444: data = {4'h0, r[4:1], g[5:2], b[4:1]};
      FMT_GRAY8:  data = {8'h00, gray};
      default:    data = pix;
    endcase
  end

endmodule

// File: rtl/ov_capture.sv
// DVP camera capture: byte pairing, format conversion, linear write
// addressing with per-line realignment and malformed-frame flagging.
module ov_capture
  import ov_pkg::*;
#(
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   ADDR_W      = 19,
  parameter int   SKIP_FRAMES = 2,
  parameter logic VSYNC_POL   = VSYNC_POL_LOW
) (
  input  logic              PCLK_OV,
  input  logic              rst,
  input  logic              VSYNC_OV,
  input  logic              HREF_OV,
  input  logic [7:0]        OV_Data_in,
  input  logic              cap_en,
  input  logic [1:0]        fmt,
  output logic [15:0]       OV_Data_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] r_addr,
  output logic              frame_done,
  output logic              frame_err,
  output ov_state_e         dbg_state
);

  localparam int COL_W     = $clog2(H_ACTIVE + 1);
  localparam int ROW_W     = $clog2(V_ACTIVE + 2);
  localparam int SKIP_W    = $clog2(SKIP_FRAMES + 2);
  localparam int SKIP_LAST = (SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0;

  ov_state_e state, state_next;

  logic       vs_r, hr_r, vs_blank_q, hr_q;
  logic [7:0] d_r;
  logic       vs_blank, vs_enter, vs_leave, href_rise, href_fall;
  logic       frame_start, frame_end;

  logic [SKIP_W-1:0] skip_cnt;
  logic [1:0]        fmt_q;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;
  logic              err;
  logic              active, pix_done, pix_ok;

  logic              p1_valid, p1_done, p1_err;
  logic [15:0]       p1_pix;
  logic [ADDR_W-1:0] p1_addr;
  logic [15:0]       fmt_data;

  assign dbg_state = state;

  // Sensor inputs are registered once; all edges come from these copies.
  always_ff @(posedge PCLK_OV or negedge rst) begin
    if (!rst) begin
      vs_r       <= ~VSYNC_POL;
      hr_r       <= 1'b0;
      d_r        <= 8'h00;
      vs_blank_q <= 1'b0;
      hr_q       <= 1'b0;
    end else begin
      vs_r       <= VSYNC_OV;
      hr_r       <= HREF_OV;
      d_r        <= OV_Data_in;
      vs_blank_q <= vs_blank;
      hr_q       <= hr_r;
    end
  end

  assign vs_blank  = (vs_r == VSYNC_POL);
  assign vs_enter  = vs_blank & ~vs_blank_q;
  assign vs_leave  = ~vs_blank & vs_blank_q;
  assign href_rise = hr_r & ~hr_q;
  assign href_fall = ~hr_r & hr_q;

  always_ff @(posedge PCLK_OV or negedge rst) begin
    if (!rst) state <= SYNC_WAIT;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (vs_blank) state_next = (SKIP_FRAMES == 0) ? ARMED : SKIP;
      end
      SKIP: begin
        if (vs_enter && (skip_cnt == SKIP_W'(SKIP_LAST))) state_next = ARMED;
      end
      ARMED: begin
        if (vs_leave) begin
          frame_start = 1'b1;
          state_next  = cap_en ? ACTIVE : IGNORE;
        end
      end
      ACTIVE: begin
        if (vs_enter) begin
          frame_end  = 1'b1;
          state_next = ARMED;
        end
      end
      IGNORE: begin
        if (vs_enter) state_next = ARMED;
      end
      default: state_next = SYNC_WAIT;
    endcase
  end

  // Counts sync entries only while settling; restarts from every reset.
  always_ff @(posedge PCLK_OV or negedge rst) begin
    if (!rst) begin
      skip_cnt <= '0;
    end else if (state == SYNC_WAIT) begin
      skip_cnt <= '0;
    end else if ((state == SKIP) && vs_enter) begin
      skip_cnt <= skip_cnt + SKIP_W'(1);
    end
  end

  assign active   = (state == ACTIVE);
  assign pix_done = active & hr_r & ~href_rise & phase;
  assign pix_ok   = pix_done & (col < COL_W'(H_ACTIVE)) & (row < ROW_W'(V_ACTIVE));

  always_ff @(posedge PCLK_OV or negedge rst) begin
    if (!rst) begin
      fmt_q    <= FMT_RGB565;
      phase    <= 1'b0;
      hi_byte  <= 8'h00;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      err      <= 1'b0;
    end else if (frame_start) begin
      fmt_q    <= fmt;
      phase    <= 1'b0;
      col      <= '0;
      row      <= '0;
      row_base <= '0;
      err      <= 1'b0;
    end else if (active) begin
      if (hr_r) begin
        if (href_rise || !phase) begin
          hi_byte <= d_r;
          phase   <= 1'b1;
        end else begin
          phase <= 1'b0;
          if (pix_ok) col <= col + COL_W'(1);
          else        err <= 1'b1;
        end
      end else if (href_fall) begin
        // A trailing lone byte is dropped here along with the line.
        if ((col != COL_W'(H_ACTIVE)) || phase) err <= 1'b1;
        phase <= 1'b0;
        col   <= '0;
        if (row != ROW_W'(V_ACTIVE + 1)) row <= row + ROW_W'(1);
        if (row < ROW_W'(V_ACTIVE - 1)) row_base <= row_base + ADDR_W'(H_ACTIVE);
      end
    end
  end

  // Stage 1: assembled pixel, address and end-of-frame status.
  always_ff @(posedge PCLK_OV or negedge rst) begin
    if (!rst) begin
      p1_valid <= 1'b0;
      p1_pix   <= 16'h0000;
      p1_addr  <= '0;
      p1_done  <= 1'b0;
      p1_err   <= 1'b0;
    end else begin
      p1_valid <= pix_ok;
      p1_done  <= frame_end;
      p1_err   <= err | (row != ROW_W'(V_ACTIVE));
      if (pix_ok) begin
        p1_pix  <= {hi_byte, d_r};
        p1_addr <= row_base + ADDR_W'(col);
      end
    end
  end

  ov_pix_fmt u_pix_fmt (
    .pix  (p1_pix),
    .fmt  (fmt_q),
    .data (fmt_data)
  );

  // wr_en is a one-cycle strobe with no back-pressure: the frame buffer
  // must accept data/address in the cycle wr_en is high. Data and address
  // hold their last written value between strobes.
  always_ff @(posedge PCLK_OV or negedge rst) begin
    if (!rst) begin
      OV_Data_out <= 16'h0000;
      wr_en       <= 1'b0;
      r_addr      <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_en      <= p1_valid;
      frame_done <= p1_done;
      frame_err  <= p1_done & p1_err;
      if (p1_valid) begin
        OV_Data_out <= fmt_data;
        r_addr      <= p1_addr;
      end
    end
  end

endmodule

// File: tb/tb_ov_capture.sv
// Directed bench for ov_capture with a 4x2 window: one instance without
// frame skipping and one that discards two frames after reset.
module tb_ov_capture;
  import ov_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync, href, cap_en;
  logic [7:0] din;
  logic [1:0] fmt;

  logic [15:0] data0, data1;
  logic        wr0, wr1, done0, done1, ferr0, ferr1;
  logic [2:0]  addr0, addr1;
  ov_state_e   st0, st1;

  logic [18:0] got0_q[$];
  logic [18:0] got1_q[$];
  logic [18:0] exp_q[$];
  logic        done0_q[$];
  int          done1_cnt;
  logic [7:0]  lb[0:15];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ov_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(3), .SKIP_FRAMES(0), .VSYNC_POL(1'b0)) dut0 (
    .PCLK_OV(clk), .rst(rst), .VSYNC_OV(vsync), .HREF_OV(href), .OV_Data_in(din),
    .cap_en(cap_en), .fmt(fmt), .OV_Data_out(data0), .wr_en(wr0), .r_addr(addr0),
    .frame_done(done0), .frame_err(ferr0), .dbg_state(st0)
  );

  ov_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(3), .SKIP_FRAMES(2), .VSYNC_POL(1'b0)) dut1 (
    .PCLK_OV(clk), .rst(rst), .VSYNC_OV(vsync), .HREF_OV(href), .OV_Data_in(din),
    .cap_en(cap_en), .fmt(fmt), .OV_Data_out(data1), .wr_en(wr1), .r_addr(addr1),
    .frame_done(done1), .frame_err(ferr1), .dbg_state(st1)
  );

  // Output capture on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (wr0)   got0_q.push_back({addr0, data0});
    if (done0) done0_q.push_back(ferr0);
    if (wr1)   got1_q.push_back({addr1, data1});
    if (done1) done1_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    got0_q.delete();
    got1_q.delete();
    exp_q.delete();
    done0_q.delete();
    done1_cnt = 0;
  endtask

  task automatic fill_line(input logic [15:0] p0, p1, p2, p3);
    lb[0] = p0[15:8]; lb[1] = p0[7:0];
    lb[2] = p1[15:8]; lb[3] = p1[7:0];
    lb[4] = p2[15:8]; lb[5] = p2[7:0];
    lb[6] = p3[15:8]; lb[7] = p3[7:0];
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href = 1'b1;
      din  = lb[i];
    end
    @(negedge clk);
    href = 1'b0;
    din  = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_open();
    @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_close();
    @(negedge clk);
    vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] a, input logic [15:0] b);
    frame_open();
    fill_line(a, a, a, a);
    send_line(8);
    fill_line(b, b, b, b);
    send_line(8);
    frame_close();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; vsync = 1'b0; href = 1'b0; din = 8'h00; cap_en = 1'b1; fmt = 2'd0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (data0 !== 16'h0000) begin tests_failed++; $display("FAIL reset_data got %h exp 0000", data0); end
    tests_run++;
    if (wr0 !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en got %b exp 0", wr0); end
    tests_run++;
    if (addr0 !== 3'd0) begin tests_failed++; $display("FAIL reset_addr got %0d exp 0", addr0); end
    tests_run++;
    if ({done0, ferr0} !== 2'b00) begin tests_failed++; $display("FAIL reset_done got %b exp 00", {done0, ferr0}); end
    tests_run++;
    if (st0 !== SYNC_WAIT || st1 !== SYNC_WAIT) begin
      tests_failed++; $display("FAIL reset_state got %0d/%0d exp %0d", st0, st1, SYNC_WAIT);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (st0 !== ARMED) begin tests_failed++; $display("FAIL armed_state got %0d exp %0d", st0, ARMED); end
  endtask

  task automatic test_basic();
    clear_obs();
    fmt = 2'd0; cap_en = 1'b1;
    run_frame(16'hF800, 16'hF800);
    for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 16'hF800});
    tests_run++;
    if (got0_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL basic_wr_count got %0d exp %0d", got0_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
      tests_run++;
      if (got0_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL basic_wr[%0d] got %h exp %h", i, got0_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (done0_q.size() != 1 || done0_q[0] !== 1'b0) begin
      tests_failed++; $display("FAIL basic_done got %0d pulses exp 1 with err 0", done0_q.size());
    end
  endtask

  task automatic test_formats();
    // RGB444 latched at frame start; the mid-frame change to GRAY8 is ignored.
    clear_obs();
    fmt = 2'd1;
    frame_open();
    fmt = 2'd2;
    fill_line(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    send_line(8);
    send_line(8);
    frame_close();
    tests_run++;
    if (got0_q.size() != 8) begin tests_failed++; $display("FAIL rgb444_wr_count got %0d exp 8", got0_q.size()); end
    for (int i = 0; i < got0_q.size(); i++) begin
      tests_run++;
      if (got0_q[i] !== {3'(i), 16'h0FFF}) begin
        tests_failed++; $display("FAIL rgb444_wr[%0d] got %h exp %h", i, got0_q[i], {3'(i), 16'h0FFF});
      end
    end
    clear_obs();
    run_frame(16'hF800, 16'hFFFF);
    for (int i = 0; i < 4; i++) exp_q.push_back({3'(i), 16'h003F});
    for (int i = 4; i < 8; i++) exp_q.push_back({3'(i), 16'h00FF});
    tests_run++;
    if (got0_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL gray_wr_count got %0d exp %0d", got0_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
      tests_run++;
      if (got0_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL gray_wr[%0d] got %h exp %h", i, got0_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_long_line();
    clear_obs();
    fmt = 2'd0;
    frame_open();
    fill_line(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    lb[8] = 8'h11; lb[9] = 8'h11;
    send_line(10);
    fill_line(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    send_line(8);
    frame_close();
    exp_q = '{{3'd0, 16'h1234}, {3'd1, 16'h5678}, {3'd2, 16'h9ABC}, {3'd3, 16'hDEF0},
              {3'd4, 16'h0001}, {3'd5, 16'h0002}, {3'd6, 16'h0003}, {3'd7, 16'h0004}};
    tests_run++;
    if (got0_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL long_wr_count got %0d exp %0d", got0_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
      tests_run++;
      if (got0_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL long_wr[%0d] got %h exp %h", i, got0_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (done0_q.size() != 1 || done0_q[0] !== 1'b1) begin
      tests_failed++; $display("FAIL long_err got %0d pulses exp 1 with err 1", done0_q.size());
    end
  endtask

  task automatic test_odd_line();
    clear_obs();
    frame_open();
    lb[0] = 8'h11; lb[1] = 8'h22; lb[2] = 8'h33; lb[3] = 8'h44;
    lb[4] = 8'h55; lb[5] = 8'h66; lb[6] = 8'h77;
    send_line(7);
    fill_line(16'hABCD, 16'h0102, 16'h0304, 16'h0506);
    send_line(8);
    frame_close();
    exp_q = '{{3'd0, 16'h1122}, {3'd1, 16'h3344}, {3'd2, 16'h5566},
              {3'd4, 16'hABCD}, {3'd5, 16'h0102}, {3'd6, 16'h0304}, {3'd7, 16'h0506}};
    tests_run++;
    if (got0_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL odd_wr_count got %0d exp %0d", got0_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
      tests_run++;
      if (got0_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL odd_wr[%0d] got %h exp %h", i, got0_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (done0_q.size() != 1 || done0_q[0] !== 1'b1) begin
      tests_failed++; $display("FAIL odd_err got %0d pulses exp 1 with err 1", done0_q.size());
    end
  endtask

  task automatic test_skip_and_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    clear_obs();
    fmt = 2'd0;
    run_frame(16'h0F0F, 16'h0F0F);
    run_frame(16'h0F0F, 16'h0F0F);
    tests_run++;
    if (got1_q.size() != 0 || done1_cnt != 0) begin
      tests_failed++; $display("FAIL skip_quiet got %0d writes %0d dones exp 0 0", got1_q.size(), done1_cnt);
    end
    tests_run++;
    if (got0_q.size() != 16) begin tests_failed++; $display("FAIL noskip_writes got %0d exp 16", got0_q.size()); end
    clear_obs();
    frame_open();
    fill_line(16'h1234, 16'h1234, 16'h1234, 16'h1234);
    send_line(8);
    tests_run++;
    if (got1_q.size() != 4 || got1_q.size() > 0 && got1_q[3] !== {3'd3, 16'h1234}) begin
      tests_failed++; $display("FAIL third_frame_writes got %0d exp 4 ending %h", got1_q.size(), {3'd3, 16'h1234});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      href = 1'b1;
      din  = lb[i];
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({data1, wr1, addr1, done1, ferr1} !== 22'd0) begin
      tests_failed++; $display("FAIL midframe_reset_outputs got %h exp 0", {data1, wr1, addr1, done1, ferr1});
    end
    tests_run++;
    if (st1 !== SYNC_WAIT) begin tests_failed++; $display("FAIL midframe_reset_state got %0d exp %0d", st1, SYNC_WAIT); end
    repeat (2) @(negedge clk);
    clear_obs();
    rst = 1'b1;
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      din = lb[i];
    end
    @(negedge clk);
    href = 1'b0;
    repeat (3) @(negedge clk);
    frame_close();
    tests_run++;
    if (got0_q.size() != 0 || got1_q.size() != 0 || done0_q.size() != 0) begin
      tests_failed++; $display("FAIL partial_frame got %0d/%0d writes exp 0", got0_q.size(), got1_q.size());
    end
    run_frame(16'h00AA, 16'h00AA);
    tests_run++;
    if (got0_q.size() != 8 || done0_q.size() != 1) begin
      tests_failed++; $display("FAIL after_reset_capture got %0d writes exp 8", got0_q.size());
    end
    tests_run++;
    if (got1_q.size() != 0) begin tests_failed++; $display("FAIL skip_restart got %0d writes exp 0", got1_q.size()); end
  endtask

  task automatic test_cap_en();
    clear_obs();
    cap_en = 1'b0;
    frame_open();
    tests_run++;
    if (st0 !== IGNORE) begin tests_failed++; $display("FAIL ignore_state got %0d exp %0d", st0, IGNORE); end
    cap_en = 1'b1;
    fill_line(16'h5555, 16'h5555, 16'h5555, 16'h5555);
    send_line(8);
    send_line(8);
    frame_close();
    tests_run++;
    if (got0_q.size() != 0 || done0_q.size() != 0) begin
      tests_failed++; $display("FAIL ignored_frame got %0d writes %0d dones exp 0 0", got0_q.size(), done0_q.size());
    end
    run_frame(16'h5555, 16'hAAAA);
    tests_run++;
    if (got0_q.size() != 8) begin
      tests_failed++; $display("FAIL recapture_count got %0d exp 8", got0_q.size());
    end else begin
      tests_run++;
      if (got0_q[0] !== {3'd0, 16'h5555} || got0_q[7] !== {3'd7, 16'hAAAA}) begin
        tests_failed++; $display("FAIL recapture_data got %h %h exp %h %h", got0_q[0], got0_q[7], {3'd0, 16'h5555}, {3'd7, 16'hAAAA});
      end
    end
    tests_run++;
    if (done0_q.size() != 1 || done0_q[0] !== 1'b0) begin
      tests_failed++; $display("FAIL recapture_done got %0d pulses exp 1 with err 0", done0_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_formats();
    test_long_line();
    test_odd_line();
    test_skip_and_reset();
    test_cap_en();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
